input_conditioner: RTL and testbench

Front-end stage between the board pins (KEY, SW) and `main_control` / `datapath`. It synchronises the asynchronous KEY and SW inputs to CLOCK_50 and debounces them. It produces clean single-cycle press/release pulses for the controllers (replacing the raw `~KEY[n]` hookups) and a glitch-free switch vector for `input_amount` / `input_key`.

---
 rtl/input_conditioner.sv | 105 ++++++++++
 tb/tb_input_conditioner.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Board-pin front end: two-flop synchronisers plus debounce for KEY (press/release
// pulses) and SW (stable vector with change strobe).
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_WIDTH       = 20
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [3:0] key_n,
  input  logic [9:0] sw,
  output logic [3:0] key_pressed,
  output logic [3:0] key_press_pulse,
  output logic [3:0] key_release_pulse,
  output logic [9:0] sw_stable,
  output logic       sw_changed
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [3:0]           key_meta;
  logic [3:0]           key_s;
  logic [9:0]           sw_meta;
  logic [9:0]           sw_s;
  logic [3:0]           deb_n;
  logic [CNT_WIDTH-1:0] key_cnt [4];
  logic [9:0]           cand;
  logic [CNT_WIDTH-1:0] sw_cnt;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      key_meta <= '1;
      key_s    <= '1;
      sw_meta  <= '0;
      sw_s     <= '0;
    end else begin
      key_meta <= key_n;
      key_s    <= key_meta;
      sw_meta  <= sw;
      sw_s     <= sw_meta;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      deb_n             <= '1;
      key_press_pulse   <= '0;
      key_release_pulse <= '0;
      for (int unsigned i = 0; i < 4; i++) key_cnt[i] <= '0;
    end else begin
      key_press_pulse   <= '0;
      key_release_pulse <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        if (key_s[i] == deb_n[i]) begin
          key_cnt[i] <= '0;
        end else if (key_cnt[i] == CNT_LAST) begin
          deb_n[i]             <= key_s[i];
          key_cnt[i]           <= '0;
          key_press_pulse[i]   <= ~key_s[i];
          key_release_pulse[i] <= key_s[i];
        end else begin
          key_cnt[i] <= key_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  assign key_pressed = ~deb_n;

  // The edge that loads cand already counts as the first agreeing cycle, so the
  // switch path has the same acceptance latency as the key path.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cand       <= '0;
      sw_stable  <= '0;
      sw_cnt     <= '0;
      sw_changed <= 1'b0;
    end else begin
      sw_changed <= 1'b0;
      if (sw_s != cand) begin
        cand <= sw_s;
        if (sw_s == sw_stable) begin
          sw_cnt <= '0;
        end else if (CNT_LAST == '0) begin
          sw_stable  <= sw_s;
          sw_changed <= 1'b1;
          sw_cnt     <= '0;
        end else begin
          sw_cnt <= CNT_ONE;
        end
      end else if (cand != sw_stable) begin
        if (sw_cnt == CNT_LAST) begin
          sw_stable  <= cand;
          sw_cnt     <= '0;
          sw_changed <= 1'b1;
        end else begin
          sw_cnt <= sw_cnt + CNT_ONE;
        end
      end else begin
        sw_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: expected pulse events are queued with
// their due cycle when stimulus is driven and matched as the DUT emits them.
module tb_input_conditioner;

  localparam int unsigned LAT = 6; // drive at negedge: +1 to sampling edge, +1+DEBOUNCE_CYCLES

  logic       clock = 1'b0;
  logic       resetn;
  logic [3:0] key_n;
  logic [9:0] sw;
  logic [3:0] key_pressed;
  logic [3:0] key_press_pulse;
  logic [3:0] key_release_pulse;
  logic [9:0] sw_stable;
  logic       sw_changed;

  input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH(3)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .key_n(key_n),
    .sw(sw),
    .key_pressed(key_pressed),
    .key_press_pulse(key_press_pulse),
    .key_release_pulse(key_release_pulse),
    .sw_stable(sw_stable),
    .sw_changed(sw_changed)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [9:0]  val;
  } ev_t;

  ev_t press_q[$];
  ev_t release_q[$];
  ev_t sw_q[$];

  int unsigned checks   = 0;
  int unsigned failures = 0;
  bit          mon_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_ev(input int kind, input logic [9:0] val);
    ev_t e;
    e.cyc = cyc + LAT;
    e.val = val;
    case (kind)
      0:       press_q.push_back(e);
      1:       release_q.push_back(e);
      default: sw_q.push_back(e);
    endcase
  endtask

  always @(negedge clock) begin
    ev_t e;
    if (mon_en) begin
      if (key_press_pulse !== 4'b0) begin
        if (press_q.size() == 0) check("press_unexpected", 32'(key_press_pulse), 32'd0);
        else begin
          e = press_q.pop_front();
          check("press_cycle", cyc, e.cyc);
          check("press_bits", 32'(key_press_pulse), 32'(e.val));
        end
      end
      if (key_release_pulse !== 4'b0) begin
        if (release_q.size() == 0) check("release_unexpected", 32'(key_release_pulse), 32'd0);
        else begin
          e = release_q.pop_front();
          check("release_cycle", cyc, e.cyc);
          check("release_bits", 32'(key_release_pulse), 32'(e.val));
        end
      end
      if (sw_changed !== 1'b0) begin
        if (sw_q.size() == 0) check("sw_changed_unexpected", 32'(sw_stable), 32'h3ff_ffff);
        else begin
          e = sw_q.pop_front();
          check("sw_cycle", cyc, e.cyc);
          check("sw_value", 32'(sw_stable), 32'(e.val));
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pressed"}, 32'(key_pressed), 32'h0);
    check({tag, "_press_pulse"}, 32'(key_press_pulse), 32'h0);
    check({tag, "_release_pulse"}, 32'(key_release_pulse), 32'h0);
    check({tag, "_sw_stable"}, 32'(sw_stable), 32'h0);
    check({tag, "_sw_changed"}, 32'(sw_changed), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    key_n  = 4'b0000;
    sw     = 10'h3FF;
    step(1);
    check_reset_outputs("rst1");
    step(1);
    check_reset_outputs("rst2");
    resetn = 1'b1;
    key_n  = 4'hF;
    sw     = 10'h000;
    mon_en = 1'b1;
    step(8);
    check("idle_pressed", 32'(key_pressed), 32'h0);

    // Clean press then release on key 0
    key_n[0] = 1'b0;
    push_ev(0, 10'h001);
    step(LAT - 1);
    check("press_lat_before", 32'(key_pressed), 32'h0);
    step(1);
    check("press_lat_after", 32'(key_pressed), 32'h1);
    step(20 - LAT);
    key_n[0] = 1'b1;
    push_ev(1, 10'h001);
    step(LAT - 1);
    check("release_lat_before", 32'(key_pressed), 32'h1);
    step(1);
    check("release_lat_after", 32'(key_pressed), 32'h0);
    step(4);

    // Bounce on key 1: three low cycles is one short of acceptance
    for (int k = 0; k < 10; k++) begin
      key_n[1] = 1'b0;
      step(3);
      key_n[1] = 1'b1;
      step(1);
      check("bounce_pressed", 32'(key_pressed), 32'h0);
    end
    step(8);
    check("bounce_final", 32'(key_pressed), 32'h0);

    // Simultaneous press/release on keys 0 and 3
    key_n = 4'b0110;
    push_ev(0, 10'h009);
    step(8);
    check("simul_pressed", 32'(key_pressed), 32'h9);
    key_n = 4'b1111;
    push_ev(1, 10'h009);
    step(8);
    check("simul_released", 32'(key_pressed), 32'h0);

    // Switch glitch: only the final 0x0A5 is accepted
    sw = 10'h0A5;
    step(2);
    sw = 10'h0A4;
    step(2);
    check("sw_glitch_hold", 32'(sw_stable), 32'h0);
    sw = 10'h0A5;
    push_ev(2, 10'h0A5);
    step(LAT - 1);
    check("sw_lat_before", 32'(sw_stable), 32'h0);
    step(1);
    check("sw_lat_after", 32'(sw_stable), 32'h0A5);
    step(6);

    // Reset while key 2 is mid-count
    key_n[2] = 1'b0;
    step(4);
    resetn = 1'b0;
    sw     = 10'h000;
    step(1);
    check_reset_outputs("midrst");
    resetn = 1'b1;
    push_ev(0, 10'h004);
    step(LAT - 1);
    check("midrst_before", 32'(key_pressed), 32'h0);
    step(1);
    check("midrst_after", 32'(key_pressed), 32'h4);
    key_n[2] = 1'b1;
    push_ev(1, 10'h004);
    step(10);

    check("press_q_drained", press_q.size(), 32'd0);
    check("release_q_drained", release_q.size(), 32'd0);
    check("sw_q_drained", sw_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
